pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Front end of the 5-stage pipeline. Owns the PC register and the instruction-memory request handshake.
//  Presents PCF/Instr to fetch_stage, which registers them into the F/D registers.
//  Absorbs variable-latency imem by inserting NOP bubbles and raising FetchBusy to the hazard unit.
//  Applies execute-stage redirects and discards any in-flight stale response.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PCF value after reset
//  NOP_WORD      32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk        in   1   clock
//  resetn     in   1   reset; one clock, asynchronous, active-low
//  StallF     in   1   hazard unit: hold PCF, do not consume instruction
//  PCSrcE     in   1   execute-stage redirect (taken branch/jump)
//  PCTargetE  in   32  redirect target; bits [1:0] forced to 0
//  imem_valid out  1   request valid
//  imem_addr  out  32  request address (word aligned)
//  imem_ready in   1   response strobe; imem_rdata valid in same cycle
//  imem_rdata in   32  instruction word
//  PCF        out  32  PC of instruction on Instr
//  Instr      out  32  instruction to fetch_stage (NOP_WORD when none)
//  FetchBusy  out  1   no valid instruction this cycle (hazard unit info)
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - state=BOOT, PCF=RESET_VECTOR, hold_vld=0.
//   - imem_valid=0, Instr=NOP_WORD, FetchBusy=1.
//  FSM states: BOOT, FETCH, HOLD, DRAIN.
//   - BOOT:  imem_valid=0; unconditionally -> FETCH next cycle.
//   - FETCH: imem_valid=1, imem_addr=PCF.
//   - HOLD:  imem_valid=0; Instr=hold_reg, FetchBusy=0.
//   - DRAIN: imem_valid=1, imem_addr=drain_addr (stale address kept stable).
//  FETCH transitions:
//   - ready & !StallF & !PCSrcE: Instr=imem_rdata (combinational bypass), FetchBusy=0; PCF<=PCF+4; stay FETCH.
//     Zero-wait memory sustains 1 instr/cycle.
//   - ready & StallF & !PCSrcE: hold_reg<=imem_rdata -> HOLD.
//   - !ready: Instr=NOP_WORD, FetchBusy=1, PCF holds.
//   - PCSrcE & ready: rdata discarded; PCF<=PCTargetE -> FETCH.
//   - PCSrcE & !ready: drain_addr<=PCF; PCF<=PCTargetE -> DRAIN.
//  HOLD transitions:
//   - !StallF: PCF<=PCF+4 -> FETCH.
//   - PCSrcE: PCF<=PCTargetE -> FETCH; hold_reg dropped.
//  DRAIN transitions:
//   - Instr=NOP_WORD, FetchBusy=1 throughout.
//   - on ready: rdata discarded -> FETCH.
//   - further PCSrcE: PCF<=PCTargetE; drain_addr unchanged.
//  Handshake rules:
//   - Once imem_valid=1, imem_valid and imem_addr stay stable until the ready cycle.
//   - At most one outstanding request.
//   - imem_ready while imem_valid=0 is ignored.
//  Priority: PCSrcE > StallF > normal advance.
//  Arithmetic: PCF+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
//  Async reset mid-request abandons the request. The system must also reset the imem.
// TESTING
//  T1: reset release, imem_ready tied 1 -> imem_addr 0,4,8,C on consecutive cycles;
//      Instr=rdata each cycle; FetchBusy=0 after BOOT.
//  T2: 3-cycle imem latency -> Instr=NOP_WORD and FetchBusy=1 for 2 cycles, PCF held;
//      ready cycle delivers word; PCF+4 next.
//  T3: StallF=1 on a ready cycle with rdata=32'h00500093 -> HOLD;
//      Instr stays 32'h00500093 with PCF constant for 4 stall cycles;
//      after StallF drops, next request at PCF+4.
//  T4: PCSrcE=1, PCTargetE=32'h100 while request to 32'h20 pending ->
//      imem_addr stays 32'h20 until ready; that data never appears on Instr;
//      next request at 32'h100.
//  T5: PCSrcE and StallF in same HOLD cycle, PCTargetE=32'h203 -> PCF=32'h200; next imem_addr=32'h200.
//  T6: PCF=32'hFFFF_FFFC, ready, no stall -> next PCF=0;
//      resetn pulsed low mid-FETCH -> imem_valid=0 immediately, PCF=RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch front end: owns the PC, runs the single-outstanding imem handshake,
// inserts NOP bubbles while memory is slow and squashes stale responses after redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] Instr,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_d;
  logic        hold_vld, hold_vld_d;
  logic [31:0] hold_reg, drain_addr;
  logic        load_hold, load_drain;
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  assign target_aligned = PCTargetE & 32'hFFFF_FFFC;
  assign pc_plus4       = PCF + 32'd4;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= BOOT;
      PCF      <= RESET_VECTOR;
      hold_vld <= 1'b0;
    end else begin
      state_q  <= state_d;
      PCF      <= pc_d;
      hold_vld <= hold_vld_d;
    end
  end

  // NOTE: pure data registers are left unreset; they are only read while the
  // state that loaded them is active, so a reset network would buy nothing.
  always_ff @(posedge clk) begin
    if (load_hold)  hold_reg   <= imem_rdata;
    if (load_drain) drain_addr <= PCF;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = PCF;
    hold_vld_d = hold_vld;
    load_hold  = 1'b0;
    load_drain = 1'b0;
    imem_valid = 1'b0;
    imem_addr  = PCF;
    Instr      = NOP_WORD;
    FetchBusy  = 1'b1;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (PCSrcE) pc_d = target_aligned;
      end

      FETCH: begin
        imem_valid = 1'b1;
        if (PCSrcE) begin
          // Redirect wins; an unanswered request must be drained before reissuing.
          pc_d = target_aligned;
          if (!imem_ready) begin
            load_drain = 1'b1;
            state_d    = DRAIN;
          end
        end else if (imem_ready) begin
          Instr     = imem_rdata;
          FetchBusy = 1'b0;
          if (StallF) begin
            load_hold  = 1'b1;
            hold_vld_d = 1'b1;
            state_d    = HOLD;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      HOLD: begin
        Instr     = hold_vld ? hold_reg : NOP_WORD;
        FetchBusy = !hold_vld;
        if (PCSrcE) begin
          pc_d       = target_aligned;
          hold_vld_d = 1'b0;
          state_d    = FETCH;
        end else if (!StallF) begin
          pc_d       = pc_plus4;
          hold_vld_d = 1'b0;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        // Keep the abandoned request stable until memory answers it, then drop the data.
        imem_valid = 1'b1;
        imem_addr  = drain_addr;
        if (PCSrcE)     pc_d    = target_aligned;
        if (imem_ready) state_d = FETCH;
      end

      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the fetch front end.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic        StallF, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_valid, FetchBusy;
  logic [31:0] imem_addr, PCF, Instr;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .Instr      (Instr),
    .FetchBusy  (FetchBusy)
  );

  always #5 clk = ~clk;

  // Reference model: a boot flag, a held instruction, and an abandoned request address.
  bit          m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  logic [31:0] m_stale[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_pc   = RV;
    m_held.delete();
    m_stale.delete();
  endtask

  // Drive one cycle of inputs (entered and left on a falling edge), compare, then advance the model.
  task automatic step(input logic stall, input logic pcsrc, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rd);
    logic        e_valid, e_busy;
    logic [31:0] e_addr, e_instr, tgt_al;
    StallF = stall; PCSrcE = pcsrc; PCTargetE = tgt; imem_ready = rdy; imem_rdata = rd;
    #1;
    e_addr = m_pc;
    if (m_boot) begin
      e_valid = 1'b0; e_instr = NOP; e_busy = 1'b1;
    end else if (m_held.size() != 0) begin
      e_valid = 1'b0; e_instr = m_held[0]; e_busy = 1'b0;
    end else if (m_stale.size() != 0) begin
      e_valid = 1'b1; e_addr = m_stale[0]; e_instr = NOP; e_busy = 1'b1;
    end else begin
      e_valid = 1'b1;
      if (rdy && !pcsrc) begin e_instr = rd;  e_busy = 1'b0; end
      else               begin e_instr = NOP; e_busy = 1'b1; end
    end
    check("imem_valid", {31'b0, imem_valid}, {31'b0, e_valid});
    if (e_valid) check("imem_addr", imem_addr, e_addr);
    check("Instr", Instr, e_instr);
    check("FetchBusy", {31'b0, FetchBusy}, {31'b0, e_busy});
    check("PCF", PCF, m_pc);

    @(posedge clk);
    tgt_al = {tgt[31:2], 2'b00};
    if (m_boot) begin
      m_boot = 1'b0;
      if (pcsrc) m_pc = tgt_al;
    end else if (m_held.size() != 0) begin
      if (pcsrc)       begin m_pc = tgt_al;    m_held.delete(); end
      else if (!stall) begin m_pc = m_pc + 4;  m_held.delete(); end
    end else if (m_stale.size() != 0) begin
      if (pcsrc) m_pc = tgt_al;
      if (rdy)   m_stale.delete();
    end else if (pcsrc) begin
      if (!rdy) m_stale.push_back(m_pc);
      m_pc = tgt_al;
    end else if (rdy) begin
      if (stall) m_held.push_back(rd);
      else       m_pc = m_pc + 4;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst imem_valid", {31'b0, imem_valid}, 32'd0);
    check("rst PCF", PCF, RV);
    check("rst Instr", Instr, NOP);
    check("rst FetchBusy", {31'b0, FetchBusy}, 32'd1);
    @(posedge clk);
    #1;
    check("rst held PCF", PCF, RV);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    StallF = 0; PCSrcE = 0; PCTargetE = 0; imem_ready = 0; imem_rdata = 0;
    do_reset();

    // T1: zero-wait memory after boot streams sequential addresses.
    step(0, 0, 0, 1, 32'hAAAA_0000);
    for (int i = 0; i < 4; i++) begin
      check("t1 imem_addr", imem_addr, 32'(4 * i));
      step(0, 0, 0, 1, 32'h1000_0000 + 32'(i));
    end

    // T2: three-cycle latency holds the PC and emits bubbles.
    step(0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, $urandom);
    check("t2 PCF held", PCF, 32'h10);
    step(0, 0, 0, 1, 32'h0000_0513);
    check("t2 PCF next", PCF, 32'h14);

    // T3: stall on the ready cycle parks the word.
    step(1, 0, 0, 1, 32'h0050_0093);
    for (int i = 0; i < 4; i++) begin
      check("t3 Instr held", Instr, 32'h0050_0093);
      check("t3 PCF held", PCF, 32'h14);
      step(1, 0, 0, 1'($urandom), $urandom);
    end
    step(0, 0, 0, 0, $urandom);
    check("t3 next addr", imem_addr, 32'h18);

    // T4: redirect during a pending request drains it.
    step(0, 1, 32'h20, 1, $urandom);
    step(0, 1, 32'h100, 0, $urandom);
    check("t4 drain valid", {31'b0, imem_valid}, 32'd1);
    check("t4 drain addr", imem_addr, 32'h20);
    step(0, 0, 0, 0, $urandom);
    check("t4 drain addr2", imem_addr, 32'h20);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    check("t4 new addr", imem_addr, 32'h100);
    check("t4 PCF", PCF, 32'h100);

    // T5: redirect beats stall in HOLD; target is word aligned.
    step(1, 0, 0, 1, 32'h1111_1111);
    step(1, 1, 32'h203, 0, $urandom);
    check("t5 PCF", PCF, 32'h200);
    check("t5 addr", imem_addr, 32'h200);

    // T6: PC wrap, then asynchronous reset during a pending request.
    step(0, 1, 32'hFFFF_FFFC, 1, $urandom);
    check("t6 PCF top", PCF, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, $urandom);
    check("t6 PCF wrap", PCF, 32'h0);
    step(0, 0, 0, 0, $urandom);
    #2;
    do_reset();

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        do_reset();
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) < 6, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
